// File: rtl/eros_obi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eros_obi_pkg
//  Description : Shared OBI request-channel type. The lockstep checker
//                compares these fields between the two harts.
//  Revision    : 1.0  initial release
// ============================================================================
package eros_obi_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

endpackage : eros_obi_pkg
`default_nettype wire

// File: rtl/lockstep_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lockstep_cmp_pkg
//  Description : Types shared by the lockstep request comparator: FSM state
//                encoding and the divergence cause code.
//  Revision    : 1.0  initial release
// ============================================================================
package lockstep_cmp_pkg;

    localparam int ERR_CAUSE_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        CHECK  = 2'd2,
        FAULT  = 2'd3
    } lockstep_cmp_state_t;

    // Bit 0 = instruction path diverged, bit 1 = data path diverged.
    typedef enum logic [ERR_CAUSE_W-1:0] {
        NONE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2,
        BOTH  = 2'd3
    } err_cause_e;

endpackage : lockstep_cmp_pkg
`default_nettype wire

// File: rtl/obi_req_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : obi_req_cmp
//  Description : Purely combinational comparison of two OBI requests.
//                Fields are only compared when both sides request. With
//                CHECK_DATA set, we/be are compared and wdata is compared only
//                in byte lanes enabled by be on a write.
//  Ports       : i_req_a, i_req_b - requests from hart 0 and hart 1
//                o_diverge        - 1 when the two requests differ
//  Revision    : 1.0  initial release
// ============================================================================
module obi_req_cmp
    import eros_obi_pkg::*;
#(
    parameter bit CHECK_DATA = 1'b1
) (
    input  obi_req_t i_req_a,
    input  obi_req_t i_req_b,
    output logic     o_diverge
);

    logic        w_req_diff;
    logic        w_both_req;
    logic        w_addr_diff;
    logic        w_ctl_diff;
    logic        w_wdata_diff;
    logic [31:0] w_lane_mask;

    assign w_req_diff  = i_req_a.req ^ i_req_b.req;
    assign w_both_req  = i_req_a.req & i_req_b.req;
    assign w_addr_diff = (i_req_a.addr != i_req_b.addr);

    // When be differs the cycle is already divergent, so hart 0's be alone
    // is enough to select the lanes that matter.
    assign w_lane_mask = {{8{i_req_a.be[3]}}, {8{i_req_a.be[2]}},
                          {8{i_req_a.be[1]}}, {8{i_req_a.be[0]}}};

    assign w_ctl_diff   = CHECK_DATA &&
                          ((i_req_a.we != i_req_b.we) || (i_req_a.be != i_req_b.be));
    assign w_wdata_diff = CHECK_DATA && i_req_a.we && i_req_b.we &&
                          (((i_req_a.wdata ^ i_req_b.wdata) & w_lane_mask) != 32'h0);

    assign o_diverge = w_req_diff ||
                       (w_both_req && (w_addr_diff || w_ctl_diff || w_wdata_diff));

endmodule : obi_req_cmp
`default_nettype wire

// File: rtl/lockstep_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : lockstep_cmp
//  Description : Delayed-lockstep request checker. Compares the time-aligned
//                instruction and data OBI requests of two harts every cycle,
//                pulses a mismatch flag, holds a sticky fault with the cause
//                and hart-0 address of the first divergence until software
//                acknowledges, and counts divergent cycles (saturating).
//  Ports       : clk_i, rst_i      - clock, synchronous active-high reset
//                enable_i          - lockstep active
//                instr_req_i[1:0]  - aligned instruction requests per hart
//                data_req_i[1:0]   - aligned data requests per hart
//                err_ack_i         - software acknowledge of the fault
//                mismatch_o        - one-cycle pulse per divergent cycle
//                error_o           - sticky fault level
//                err_cause_o       - 0 none, 1 instr, 2 data, 3 both
//                err_addr_o        - captured hart-0 address
//                err_cnt_o         - saturating divergence count
//  Revision    : 1.0  initial release
// ============================================================================
module lockstep_cmp
    import eros_obi_pkg::*;
    import lockstep_cmp_pkg::*;
#(
    parameter int NCYCLES   = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  obi_req_t [1:0]         instr_req_i,
    input  obi_req_t [1:0]         data_req_i,
    input  logic                   err_ack_i,
    output logic                   mismatch_o,
    output logic                   error_o,
    output logic [ERR_CAUSE_W-1:0] err_cause_o,
    output logic [31:0]            err_addr_o,
    output logic [ERR_CNT_W-1:0]   err_cnt_o
);

    localparam int WARM_W = (NCYCLES < 1) ? 1 : $clog2(NCYCLES + 1);

    lockstep_cmp_state_t  r_state;
    logic [WARM_W-1:0]    r_warm;
    logic                 r_mismatch;
    logic                 r_error;
    err_cause_e           r_cause;
    logic [31:0]          r_addr;
    logic [ERR_CNT_W-1:0] r_cnt;

    logic       w_instr_div;
    logic       w_data_div;
    logic       w_live;
    logic       w_instr_hit;
    logic       w_data_hit;
    logic       w_any;
    err_cause_e w_cause;
    logic [31:0] w_addr;

    obi_req_cmp #(
        .CHECK_DATA (1'b0)
    ) u_cmp_instr (
        .i_req_a   (instr_req_i[0]),
        .i_req_b   (instr_req_i[1]),
        .o_diverge (w_instr_div)
    );

    obi_req_cmp #(
        .CHECK_DATA (1'b1)
    ) u_cmp_data (
        .i_req_a   (data_req_i[0]),
        .i_req_b   (data_req_i[1]),
        .o_diverge (w_data_div)
    );

    // Comparison is live in CHECK, and in FAULT only while lockstep is enabled.
    assign w_live      = enable_i && ((r_state == CHECK) || (r_state == FAULT));
    assign w_instr_hit = w_live && w_instr_div;
    assign w_data_hit  = w_live && w_data_div;
    assign w_any       = w_instr_hit || w_data_hit;
    assign w_cause     = err_cause_e'({w_data_hit, w_instr_hit});
    // Instruction address wins when both paths diverge.
    assign w_addr      = w_instr_hit ? instr_req_i[0].addr : data_req_i[0].addr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_warm     <= '0;
            r_mismatch <= 1'b0;
            r_error    <= 1'b0;
            r_cause    <= NONE;
            r_addr     <= 32'h0;
            r_cnt      <= '0;
        end else begin
            r_mismatch <= w_any;
            if (w_any && (r_cnt != {ERR_CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (enable_i) begin
                        r_warm  <= WARM_W'(NCYCLES);
                        // The IDLE cycle that sees enable is itself masked,
                        // so NCYCLES more WARMUP cycles complete the fill.
                        r_state <= (NCYCLES == 0) ? CHECK : WARMUP;
                    end
                end
                WARMUP: begin
                    if (!enable_i) begin
                        r_state <= IDLE;
                    end else if (r_warm <= WARM_W'(1)) begin
                        r_warm  <= '0;
                        r_state <= CHECK;
                    end else begin
                        r_warm <= r_warm - 1'b1;
                    end
                end
                CHECK: begin
                    if (!enable_i) begin
                        r_state <= IDLE;
                    end else if (w_any) begin
                        r_error <= 1'b1;
                        r_cause <= w_cause;
                        r_addr  <= w_addr;
                        r_state <= FAULT;
                    end
                end
                FAULT: begin
                    // Capture is frozen except when an ack collides with a
                    // new divergence: the new divergence replaces it.
                    if (err_ack_i && w_any) begin
                        r_cause <= w_cause;
                        r_addr  <= w_addr;
                    end else if (err_ack_i) begin
                        r_error <= 1'b0;
                        r_cause <= NONE;
                        r_addr  <= 32'h0;
                        r_state <= enable_i ? CHECK : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mismatch_o  = r_mismatch;
    assign error_o     = r_error;
    assign err_cause_o = r_cause;
    assign err_addr_o  = r_addr;
    assign err_cnt_o   = r_cnt;

endmodule : lockstep_cmp
`default_nettype wire

// File: tb/tb_lockstep_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lockstep_cmp
//  Description : Directed self-checking bench for lockstep_cmp. A second
//                instance with a 2-bit counter shares all stimulus to cover
//                counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lockstep_cmp;
    import eros_obi_pkg::*;

    logic           clk;
    logic           rst;
    logic           enable;
    obi_req_t [1:0] instr_req;
    obi_req_t [1:0] data_req;
    logic           err_ack;

    logic        mismatch, error;
    logic [1:0]  cause;
    logic [31:0] addr;
    logic [7:0]  cnt;

    logic        s_mismatch, s_error;
    logic [1:0]  s_cause;
    logic [31:0] s_addr;
    logic [1:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    lockstep_cmp #(.NCYCLES(2), .ERR_CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .instr_req_i(instr_req), .data_req_i(data_req), .err_ack_i(err_ack),
        .mismatch_o(mismatch), .error_o(error), .err_cause_o(cause),
        .err_addr_o(addr), .err_cnt_o(cnt)
    );

    lockstep_cmp #(.NCYCLES(2), .ERR_CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .instr_req_i(instr_req), .data_req_i(data_req), .err_ack_i(err_ack),
        .mismatch_o(s_mismatch), .error_o(s_error), .err_cause_o(s_cause),
        .err_addr_o(s_addr), .err_cnt_o(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obi_req_t mk(input logic r, input logic [31:0] a,
                                    input logic w, input logic [3:0] b,
                                    input logic [31:0] d);
        obi_req_t x;
        x.req = r; x.addr = a; x.we = w; x.be = b; x.wdata = d;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        instr_req = '0;
        data_req  = '0;
        err_ack   = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        enable = 1'b0;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
    endtask

    // Enable with matching traffic and let the 3 masked cycles elapse.
    task automatic go_check();
        quiet();
        enable = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %0b expected 0", mismatch); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b expected 0", error); end
        checks++; if (cause !== 2'd0) begin errors++; $display("FAIL reset_cause: got %0d expected 0", cause); end
        checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", addr); end
        checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    endtask

    task automatic test_warmup();
        do_reset();
        enable = 1'b1;
        instr_req[0] = mk(1'b1, 32'h40, 1'b0, 4'h0, 32'h0);
        instr_req[1] = mk(1'b0, 32'h40, 1'b0, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL warmup_masked[%0d]: got %0b expected 0", i, mismatch); end
        end
        tick();
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL warmup_first_live: got %0b expected 1", mismatch); end
        checks++; if (cause !== 2'd1) begin errors++; $display("FAIL warmup_cause: got %0d expected 1", cause); end
        checks++; if (addr !== 32'h40) begin errors++; $display("FAIL warmup_addr: got %h expected 00000040", addr); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL warmup_error: got %0b expected 1", error); end
    endtask

    task automatic test_byte_mask();
        do_reset();
        go_check();
        data_req[0] = mk(1'b1, 32'h1000, 1'b1, 4'b0011, 32'hAABB1234);
        data_req[1] = mk(1'b1, 32'h1000, 1'b1, 4'b0011, 32'hCCDD1234);
        tick();
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL bytemask_masked_lanes: got %0b expected 0", mismatch); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL bytemask_no_error: got %0b expected 0", error); end
        data_req[1].wdata = 32'hAABB1235;
        tick();
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL bytemask_live_lane: got %0b expected 1", mismatch); end
        checks++; if (cause !== 2'd2) begin errors++; $display("FAIL bytemask_cause: got %0d expected 2", cause); end
        checks++; if (addr !== 32'h1000) begin errors++; $display("FAIL bytemask_addr: got %h expected 00001000", addr); end
        quiet();
        tick();
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL bytemask_pulse_end: got %0b expected 0", mismatch); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL bytemask_sticky: got %0b expected 1", error); end
    endtask

    task automatic test_first_wins();
        do_reset();
        go_check();
        instr_req[0] = mk(1'b1, 32'h80, 1'b0, 4'h0, 32'h0);
        instr_req[1] = mk(1'b1, 32'h84, 1'b0, 4'h0, 32'h0);
        tick();
        checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL first_cnt1: got %0d expected 1", cnt); end
        quiet();
        tick();
        data_req[0] = mk(1'b1, 32'h2000, 1'b0, 4'hF, 32'h0);
        data_req[1] = mk(1'b1, 32'h2004, 1'b0, 4'hF, 32'h0);
        tick();
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL first_second_pulse: got %0b expected 1", mismatch); end
        checks++; if (addr !== 32'h80) begin errors++; $display("FAIL first_addr: got %h expected 00000080", addr); end
        checks++; if (cause !== 2'd1) begin errors++; $display("FAIL first_cause: got %0d expected 1", cause); end
        checks++; if (cnt !== 8'd2) begin errors++; $display("FAIL first_cnt2: got %0d expected 2", cnt); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL first_error: got %0b expected 1", error); end
    endtask

    // Continues from the FAULT left by test_first_wins (cnt = 2).
    task automatic test_ack_race();
        quiet();
        err_ack = 1'b1;
        data_req[0] = mk(1'b1, 32'h3000, 1'b0, 4'hF, 32'h0);
        tick();
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL race_error: got %0b expected 1", error); end
        checks++; if (addr !== 32'h3000) begin errors++; $display("FAIL race_addr: got %h expected 00003000", addr); end
        checks++; if (cause !== 2'd2) begin errors++; $display("FAIL race_cause: got %0d expected 2", cause); end
        checks++; if (cnt !== 8'd3) begin errors++; $display("FAIL race_cnt: got %0d expected 3", cnt); end
        quiet();
        err_ack = 1'b1;
        tick();
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL ack_error: got %0b expected 0", error); end
        checks++; if (cause !== 2'd0) begin errors++; $display("FAIL ack_cause: got %0d expected 0", cause); end
        checks++; if (addr !== 32'h0) begin errors++; $display("FAIL ack_addr: got %h expected 0", addr); end
        // Back in CHECK: a fresh divergence is caught immediately.
        quiet();
        instr_req[0] = mk(1'b1, 32'h500, 1'b0, 4'h0, 32'h0);
        tick();
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL ack_recheck_pulse: got %0b expected 1", mismatch); end
        checks++; if (addr !== 32'h500) begin errors++; $display("FAIL ack_recheck_addr: got %h expected 00000500", addr); end
        checks++; if (cnt !== 8'd4) begin errors++; $display("FAIL ack_recheck_cnt: got %0d expected 4", cnt); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_s [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        go_check();
        instr_req[0] = mk(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (s_cnt !== exp_s[i]) begin errors++; $display("FAIL sat_cnt2[%0d]: got %0d expected %0d", i, s_cnt, exp_s[i]); end
            checks++; if (cnt !== 8'(i + 1)) begin errors++; $display("FAIL sat_cnt8[%0d]: got %0d expected %0d", i, cnt, i + 1); end
        end
        // Disabled in FAULT: comparison off, fault retained.
        enable = 1'b0;
        tick();
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL fault_disabled_pulse: got %0b expected 0", mismatch); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL fault_disabled_error: got %0b expected 1", error); end
        checks++; if (cnt !== 8'd5) begin errors++; $display("FAIL fault_disabled_cnt: got %0d expected 5", cnt); end
    endtask

    // Continues from the FAULT left by test_saturation.
    task automatic test_reset_in_fault();
        enable = 1'b1;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rstf_error: got %0b expected 0", error); end
        checks++; if (addr !== 32'h0) begin errors++; $display("FAIL rstf_addr: got %h expected 0", addr); end
        checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL rstf_cnt: got %0d expected 0", cnt); end
        checks++; if (s_cnt !== 2'd0) begin errors++; $display("FAIL rstf_cnt_sat: got %0d expected 0", s_cnt); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL rstf_mismatch: got %0b expected 0", mismatch); end
        // Divergent traffic held throughout; warm-up must mask 3 cycles again.
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL rstf_masked[%0d]: got %0b expected 0", i, mismatch); end
        end
        tick();
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL rstf_live: got %0b expected 1", mismatch); end
        checks++; if (cause !== 2'd1) begin errors++; $display("FAIL rstf_cause: got %0d expected 1", cause); end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        quiet();
        repeat (2) tick();
        test_reset();
        test_warmup();
        test_byte_mask();
        test_first_wins();
        test_ack_race();
        test_saturation();
        test_reset_in_fault();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_lockstep_cmp
`default_nettype wire

// File: doc/lockstep_cmp.md
Name: lockstep_cmp

Overview:
- Checker at the consumer end of the delayed-lockstep request path.
- Takes the two time-aligned OBI request streams for instruction and data, one per hart, and compares them cycle by cycle.
- Raises a registered mismatch pulse and a sticky fault flag. Captures the cause and address of the first divergence until software acknowledges it.
- Keeps a saturating divergence counter.
- Sits between the lockstep delay stage and the bus fabric, in parallel with the forwarded requests. It never modifies traffic.

Parameters:
- NCYCLES, 2: lockstep skew. Comparison is masked for NCYCLES+1 cycles after enable so pipeline fill is not flagged.
- ERR_CNT_W, 8: width of the divergence counter.

Ports:
- clk_i  in  1  sole clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- enable_i  in  1  lockstep active; 0 = checker idle.
- instr_req_i  in  2 x obi_req_t  aligned instruction requests, [0] and [1] per hart.
- data_req_i  in  2 x obi_req_t  aligned data requests, [0] and [1] per hart.
- err_ack_i  in  1  software acknowledge; clears the sticky fault.
- mismatch_o  out  1  one-cycle pulse per divergent cycle, registered.
- error_o  out  1  sticky fault level, used as interrupt.
- err_cause_o  out  2  cause code: 0 none, 1 instr, 2 data, 3 both.
- err_addr_o  out  32  captured addr of hart [0] at first divergence.
- err_cnt_o  out  ERR_CNT_W  saturating count of divergent cycles.

Behaviour:
- Reset (rst_i=1 at clk edge) forces every register to its reset value:
  - FSM goes to IDLE.
  - mismatch_o=0, error_o=0, err_cause_o=0, err_addr_o=0, err_cnt_o=0.
  - Warm-up counter=0.
- Reset mid-FAULT discards the capture.

Compare rules (combinational, evaluated on the current cycle):
- Instruction divergence when any of:
  - req[0] != req[1];
  - both req and addr differ.
- Data divergence when any of:
  - req differs;
  - both req and any of addr, we, be differ;
  - both req, both we=1, and wdata differs in any byte lane with be=1. Lanes with be=0 are ignored.
- Fields of a non-requesting cycle are ignored.

FSM (lockstep_cmp_state_t):
- IDLE:
  - Comparison off.
  - enable_i=1 moves to WARMUP with the warm-up counter loaded with NCYCLES.
- WARMUP:
  - Comparison masked.
  - Counter decrements each cycle; reaching 0 moves to CHECK. Masked cycles total NCYCLES+1.
  - enable_i=0 returns to IDLE. Re-enable restarts the warm-up in full.
- CHECK:
  - Comparison live.
  - A divergence in cycle t gives:
    - mismatch_o=1 in cycle t+1;
    - error_o=1 from t+1;
    - err_cause_o and err_addr_o captured at t+1;
    - err_cnt_o incremented at t+1;
    - transition to FAULT.
  - err_addr_o source: instr_req_i[0].addr if instr diverges, else data_req_i[0].addr. Instruction has priority when cause=3.
  - enable_i=0 returns to IDLE.
- FAULT:
  - error_o held at 1. Capture registers frozen; the first divergence wins.
  - Comparison continues. Each further divergent cycle pulses mismatch_o and increments err_cnt_o.
  - err_ack_i=1 with no divergence that cycle clears error_o, err_cause_o and err_addr_o on the next edge.
    - Then to CHECK if enable_i=1, else to IDLE.
  - err_ack_i=1 in the same cycle as a divergence: the divergence wins.
    - Stay in FAULT; recapture cause and addr from that cycle; increment err_cnt_o.
  - enable_i=0 in FAULT: stay in FAULT with comparison off. The fault is never lost without an ack.
- err_cnt_o:
  - Saturates at 2^ERR_CNT_W-1; no wrap.
  - Cleared only by reset.
- mismatch_o is 0 in IDLE and WARMUP regardless of inputs.

Decomposition:
- Package lockstep_cmp_pkg holds:
  - lockstep_cmp_state_t enum (IDLE, WARMUP, CHECK, FAULT);
  - err_cause_e with values NONE, INSTR, DATA, BOTH;
  - ERR_CAUSE_W=2.
- obi_req_t is reused from eros_obi_pkg.
- One sub-module, obi_req_cmp: purely combinational comparison of two obi_req_t with the byte-masked wdata rule. Instantiated twice, for instruction and data; the instruction instance ties we/be/wdata checking off via a CHECK_DATA parameter.

Test Plan:
1. Warm-up masking: NCYCLES=2, assert enable_i, drive instr_req_i[0].req=1 and [1].req=0 for cycles 0..2 -> mismatch_o stays 0. Same stimulus at cycle 3 -> mismatch_o=1 at cycle 4, err_cause_o=1.
2. Byte-masked wdata: in CHECK, both harts write addr 0x1000, be=4'b0011, wdata 0xAABB1234 vs 0xCCDD1234 -> no mismatch. Change [1] to 0xAABB1235 -> mismatch_o=1, err_cause_o=2, err_addr_o=0x1000.
3. First-wins capture: instr divergence at addr 0x80, then data divergence at addr 0x2000 two cycles later -> err_addr_o=0x80, err_cause_o=1, err_cnt_o=2, error_o held.
4. Ack/divergence race: in FAULT, err_ack_i=1 in the same cycle as a new data divergence at 0x3000 -> error_o stays 1, err_addr_o=0x3000, err_cnt_o increments. Ack alone next cycle -> error_o=0, err_cause_o=0.
5. Counter saturation: ERR_CNT_W=2, four divergent cycles -> err_cnt_o=3 and remains 3.
6. Synchronous reset mid-FAULT: rst_i=1 for one edge -> all outputs 0, FSM IDLE. With enable_i still 1, the warm-up restarts and no mismatch is flagged for NCYCLES+1 cycles.
